counter_sequencer: RTL and testbench

COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

---
 rtl/counter_sequencer.sv | 104 ++++++++++
 tb/tb_counter_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// Start/stop sequencer that clears and enables an external 4-bit up-counter up to a latched limit.
// Periodic restart is compiled in only when COUNTER_SEQ_PERIODIC_EN is defined.
module counter_sequencer (
   input  logic       clk,
   input  logic       preset,
   input  logic       start,
   input  logic       stop,
   input  logic       periodic,
   input  logic [3:0] limit,
   input  logic [3:0] cnt_q,
   output logic       cnt_en,
   output logic       cnt_clr,
   output logic       busy,
   output logic       done,
   output logic [3:0] runs
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  limit_r_q, limit_r_d;
   logic        periodic_r_q, periodic_r_d;
   logic [3:0]  runs_q, runs_d;
   logic        periodic_sel;

`ifdef COUNTER_SEQ_PERIODIC_EN
   assign periodic_sel = periodic;
`else
   // The port stays in the list; without the feature it is simply not consumed.
   logic periodic_unused;
   assign periodic_unused = periodic;
   assign periodic_sel    = 1'b0;
`endif

   always_ff @(posedge clk or posedge preset) begin
      if (preset) begin
         state_q      <= IDLE;
         limit_r_q    <= 4'd0;
         periodic_r_q <= 1'b0;
         runs_q       <= 4'd0;
      end else begin
         state_q      <= state_d;
         limit_r_q    <= limit_r_d;
         periodic_r_q <= periodic_r_d;
         runs_q       <= runs_d;
      end
   end

   // stop beats everything; start is only looked at in IDLE.
   always_comb begin
      state_d      = state_q;
      limit_r_d    = limit_r_q;
      periodic_r_d = periodic_r_q;
      runs_d       = runs_q;
      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               state_d      = CLEAR;
               limit_r_d    = limit;
               periodic_r_d = periodic_sel;
               runs_d       = 4'd0;
            end
         end
         CLEAR: begin
            state_d = stop ? IDLE : RUN;
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
            end else if (cnt_q == limit_r_q) begin
               state_d = DONE;
            end
         end
         DONE: begin
            runs_d  = runs_q + 4'd1;
            state_d = (periodic_r_q && !stop) ? CLEAR : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      cnt_en  = 1'b0;
      cnt_clr = 1'b0;
      done    = 1'b0;
      busy    = (state_q != IDLE);
      case (state_q)
         CLEAR:   cnt_clr = 1'b1;
         RUN:     cnt_en  = (cnt_q != limit_r_q);
         DONE:    done    = 1'b1;
         default: ;
      endcase
   end

   assign runs = runs_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: models the external counter and predicts each run from its cycle index.
// Honours COUNTER_SEQ_PERIODIC_EN the same way the design does.
module tb_counter_sequencer;

`ifdef COUNTER_SEQ_PERIODIC_EN
   localparam bit PER_EN = 1'b1;
`else
   localparam bit PER_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       preset = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       periodic = 1'b0;
   logic [3:0] limit = 4'd0;
   logic [3:0] cnt_q = 4'd0;
   logic       cnt_en, cnt_clr, busy, done;
   logic [3:0] runs;

   int checks = 0;
   int errors = 0;

   counter_sequencer dut (
      .clk      (clk),
      .preset   (preset),
      .start    (start),
      .stop     (stop),
      .periodic (periodic),
      .limit    (limit),
      .cnt_q    (cnt_q),
      .cnt_en   (cnt_en),
      .cnt_clr  (cnt_clr),
      .busy     (busy),
      .done     (done),
      .runs     (runs)
   );

   always #5 clk = ~clk;

   // External up-counter; preset does not touch it.
   always @(posedge clk) begin
      if (cnt_clr)     cnt_q <= 4'd0;
      else if (cnt_en) cnt_q <= cnt_q + 4'd1;
   end

   // Expected {cnt_en, cnt_clr, busy, done} in cycle k (1-based) of a run with limit L:
   // 1 = clear, 2..L+1 = counting, L+2 = counter at limit, L+3 = done.
   function automatic logic [3:0] exp_vec(input int k, input int L);
      if (k == 1)               return 4'b0110;
      else if (k <= L + 1)      return 4'b1010;
      else if (k == L + 2)      return 4'b0010;
      else                      return 4'b0011;
   endfunction

   task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [3:0] exp);
      check4(tag, {cnt_en, cnt_clr, busy, done}, exp);
   endtask

   // Issue a start, follow up to n_runs runs cycle by cycle, optionally assert stop in
   // cycle stop_at of the first run; a periodic sequence is ended by stop in its last DONE.
   task automatic run_seq(input string tag, input int L, input bit per, input int n_runs,
                          input int stop_at);
      bit         pe;
      bit         fin;
      logic [3:0] er;
      pe  = per && PER_EN;
      fin = 1'b0;
      er  = 4'd0;
      limit    = L[3:0];
      periodic = per;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int r = 0; r < n_runs && !fin; r++) begin
         for (int k = 1; k <= L + 3 && !fin; k++) begin
            if (!(r == 0 && k == 1)) begin
               @(posedge clk); #1;
            end
            check_outs({tag, "_outs"}, exp_vec(k, L));
            check4({tag, "_runs"}, runs, er);
            if (k >= 2 && k <= L + 2) check4({tag, "_cnt"}, cnt_q, 4'(k - 2));
            if (k == L + 3) er = er + 4'd1;
            if ((r == 0 && k == stop_at) || (pe && r == n_runs - 1 && k == L + 3)) begin
               stop = 1'b1;
               fin  = 1'b1;
            end else if (!pe && k == L + 3) begin
               fin = 1'b1;
            end
         end
      end
      @(posedge clk); #1;
      stop = 1'b0;
      check_outs({tag, "_idle"}, 4'b0000);
      check4({tag, "_runs_end"}, runs, er);
      @(posedge clk); #1;
      check_outs({tag, "_idle2"}, 4'b0000);
   endtask

   initial begin
      int L, per, n, s;

      // Reset state, including clock edges while held.
      #3;
      check_outs("reset_outs", 4'b0000);
      check4("reset_runs", runs, 4'd0);
      start = 1'b1;
      limit = 4'd4;
      repeat (2) @(posedge clk);
      #1;
      check_outs("reset_held", 4'b0000);
      start  = 1'b0;
      preset = 1'b0;
      @(posedge clk); #1;
      check_outs("post_reset_idle", 4'b0000);

      run_seq("oneshot5", 5, 1'b0, 1, 0);
      run_seq("limit0", 0, 1'b0, 1, 0);
      run_seq("periodic3", 3, 1'b1, 17, 0);
      run_seq("stop_run", 9, 1'b0, 1, 4);
      run_seq("stop_clear", 6, 1'b0, 1, 1);
      run_seq("stop_done", 2, 1'b0, 1, 5);

      // start held while busy with a different limit must not disturb the run.
      limit    = 4'd4;
      periodic = 1'b0;
      start    = 1'b1;
      @(posedge clk); #1;
      limit = 4'd1;
      for (int k = 1; k <= 7; k++) begin
         if (k > 1) begin
            @(posedge clk); #1;
         end
         check_outs("hold_start_outs", exp_vec(k, 4));
         if (k == 7) start = 1'b0;
      end
      @(posedge clk); #1;
      check_outs("hold_start_idle", 4'b0000);
      check4("hold_start_runs", runs, 4'd1);

      // start and stop together in IDLE: stop wins.
      start = 1'b1;
      stop  = 1'b1;
      limit = 4'd5;
      @(posedge clk); #1;
      start = 1'b0;
      stop  = 1'b0;
      check_outs("start_stop_idle", 4'b0000);
      check4("start_stop_runs", runs, 4'd1);

      // preset clears runs asynchronously.
      #2 preset = 1'b1;
      #1;
      check4("preset_runs", runs, 4'd0);
      #2 preset = 1'b0;

      // preset mid-run: outputs drop before any clock edge.
      @(posedge clk); #1;
      limit = 4'd7;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_outs("pre_preset_run", 4'b1010);
      #2 preset = 1'b1;
      #1;
      check_outs("preset_async", 4'b0000);
      @(posedge clk); #1;
      check_outs("preset_held", 4'b0000);
      preset = 1'b0;
      @(posedge clk); #1;
      check_outs("preset_no_done", 4'b0000);
      run_seq("after_preset", 2, 1'b0, 1, 0);

      // Randomized runs.
      for (int i = 0; i < 12; i++) begin
         L   = $urandom_range(0, 15);
         per = $urandom_range(0, 1);
         n   = $urandom_range(1, 3);
         s   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, L + 3) : 0;
         run_seq("rand", L, per[0], n, s);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
